gcn_batch_scheduler: RTL

GCN_BATCH_SCHEDULER -- requirements
Module: gcn_batch_scheduler

---
 rtl/gcn_batch_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gcn_batch_scheduler.sv
// Purpose: sequences a batch of graphs through the GCN datapath and queues each argmax answer in a result FIFO.
// Latency: batch_start->gcn_reset 1 cycle, ->gcn_start 2 cycles; gcn_done->push 1 cycle, ->res_valid 2 cycles.
// Backpressure: res_valid/res_ready; a full FIFO stalls the scheduler in STORE. Optional watchdog: GCN_SCHED_TIMEOUT_EN.
module gcn_batch_scheduler #(
    parameter int FEATURE_ROWS      = 6,
    parameter int MAX_ADDRESS_WIDTH = 2,
    parameter int CNT_W             = 4,
    parameter int FIFO_DEPTH        = 4,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    batch_start,
    input  logic [CNT_W-1:0]                        batch_count,
    output logic                                    gcn_reset,
    output logic                                    gcn_start,
    input  logic                                    gcn_done,
    input  logic [MAX_ADDRESS_WIDTH-1:0]            gcn_answer [0:FEATURE_ROWS-1],
    output logic [CNT_W-1:0]                        graph_index,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [FEATURE_ROWS*MAX_ADDRESS_WIDTH-1:0] res_data,
    output logic [CNT_W-1:0]                        res_graph,
    output logic                                    busy,
    output logic                                    batch_done,
    output logic                                    err
);

    localparam int DATA_W = FEATURE_ROWS * MAX_ADDRESS_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [CNT_W-1:0]  graph;
        logic [DATA_W-1:0] answer;
    } res_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LAUNCH, S_WAIT, S_STORE, S_NEXT, S_FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count_lat;
    logic [DATA_W-1:0] answer_pk;
    res_t             push_dat;
    logic             push_vld;
    logic             pop_vld;
    logic             fifo_full;
    res_t             mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FILL_W-1:0] fill;

`ifdef GCN_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic            err_q;
    logic [WD_W-1:0] wd_cnt;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        answer_pk = '0;
        for (int i = 0; i < FEATURE_ROWS; i++) begin
            answer_pk[i*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH] = gcn_answer[i];
        end
    end

    // Full is judged on the registered fill, so a same-cycle pop never frees a slot for STORE.
    assign fifo_full       = (fill == FILL_W'(FIFO_DEPTH));
    assign push_vld        = (state == S_STORE) && !fifo_full;
    assign push_dat.graph  = graph_index;
    assign push_dat.answer = answer_pk;
    assign res_valid       = (fill != '0);
    assign pop_vld         = res_valid && res_ready;
    assign res_data        = res_valid ? mem[rd_ptr].answer : '0;
    assign res_graph       = res_valid ? mem[rd_ptr].graph  : '0;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_vld, pop_vld})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            gcn_reset   <= 1'b1;
            gcn_start   <= 1'b0;
            graph_index <= '0;
            count_lat   <= '0;
            busy        <= 1'b0;
            batch_done  <= 1'b0;
`ifdef GCN_SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            gcn_reset  <= 1'b0;
            gcn_start  <= 1'b0;
            batch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (batch_start) begin
                        busy <= 1'b1;
`ifdef GCN_SCHED_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                        if (batch_count != '0) begin
                            count_lat   <= batch_count;
                            graph_index <= '0;
                            gcn_reset   <= 1'b1;
                            state       <= S_CLR;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
                S_CLR: begin
                    gcn_start <= 1'b1;
                    state     <= S_LAUNCH;
                end
                S_LAUNCH: begin
`ifdef GCN_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (gcn_done) begin
                        state <= S_STORE;
                    end
`ifdef GCN_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_STORE: begin
                    if (!fifo_full) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (graph_index == count_lat - 1'b1) begin
                        state <= S_FIN;
                    end else begin
                        graph_index <= graph_index + 1'b1;
                        gcn_reset   <= 1'b1;
                        state       <= S_CLR;
                    end
                end
                S_FIN: begin
                    batch_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
